debug_run_ctrl: RTL and testbench
=================================

Name: debug_run_ctrl

Overview:
Run-control sequencer for the RISC-V core's debug mode. It decodes host commands latched by the Avalon debug slave (reg0 control fields) and produces the core freeze controls (debug, enable_ext, enable_pc_ext). Supported operations are halt, resume, single-step, run-N-instructions and PC breakpoint. It drains the pipeline before reporting HALTED, and raises tx_flag so the host can read status.

Parameters:
PIPE_DEPTH, 4, cycles to drain in-flight instructions after the PC is frozen (one per stage).
STEP_TIMEOUT, 64, max cycles to wait for core_retire in STEPPING.
HALT_ON_RESET, 0, 1 = leave reset in HALTED; 0 = leave reset in RUNNING.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-low
ctrl_valid  in  1  one-cycle pulse: new command written by host
ctrl_cmd  in  3  0 NOP, 1 HALT, 2 RESUME, 3 STEP, 4 RUN_N, 5 CLR_ERR; 6–7 illegal
step_count  in  16  instruction count for RUN_N, sampled with ctrl_valid
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC (reg1)
pc_current  in  32  PC of instruction being fetched
core_retire  in  1  one-cycle pulse per retired instruction
debug  out  1  core is in debug (not free-running)
enable_ext  out  4  stage enables {WB,EX,ID,IF}
enable_pc_ext  out  1  PC update enable
tx_flag  out  1  one-cycle pulse on entry to HALTED
status  out  32  [1:0] state, [4:2] halt cause, [5] cmd_err sticky, [6] timeout sticky, [31:16] retires since last RESUME/STEP/RUN_N

Behaviour:
- Moore outputs are decoded from the state register. ctrl_valid is sampled on the rising edge, and the new state's outputs appear on the following cycle.
- Reset (RST=0): state = HALTED if HALT_ON_RESET else RUNNING. All counters, cause, cmd_err and timeout = 0. tx_flag = 0. Reset mid-operation aborts the operation with no tx_flag.
- States and outputs:
  - RUNNING: debug=0, enable_ext=4'hF, enable_pc_ext=1.
  - DRAIN: debug=1, enable_ext=4'hF, enable_pc_ext=0. A counter runs PIPE_DEPTH cycles, then the block enters HALTED.
  - HALTED: debug=1, enable_ext=0, enable_pc_ext=0. tx_flag=1 for exactly the first cycle only.
  - STEPPING: debug=1, enable_ext=4'hF, enable_pc_ext=1 for the first cycle only.
- Halt cause codes: 0 reset, 1 host, 2 breakpoint, 3 count, 4 step, 5 timeout.
- Transitions:
  - RUNNING + HALT → DRAIN, cause host.
  - RUNNING + bp_en & pc_current==bp_addr → DRAIN, cause bp. The compare is masked for the first cycle after any RESUME/RUN_N entry, so the core can leave a breakpoint it is halted on.
  - RUNNING in RUN_N mode: a 16-bit counter increments on core_retire. When it equals step_count → DRAIN, cause count. If bp and count occur in the same cycle, bp wins. A host HALT in the same cycle as bp has lower priority than bp.
  - HALTED + RESUME → RUNNING (free mode). HALTED + RUN_N → RUNNING (count mode).
  - HALTED + STEP → STEPPING. In STEPPING, core_retire → HALTED, cause step. STEP_TIMEOUT cycles without a retire → HALTED, cause timeout, timeout bit set.
- Illegal or inapplicable commands are ignored and set cmd_err: RESUME/STEP/RUN_N while not HALTED, any command except CLR_ERR during DRAIN/STEPPING, RUN_N with step_count=0, and ctrl_cmd 6–7.
- HALT while HALTED, and NOP, are silent no-ops.
- CLR_ERR clears cmd_err and timeout in any state, with no state change.
- status[31:16] saturates at 16'hFFFF.

Decomposition:
- Package debug_ctrl_pkg:
  - state enum {RUNNING, DRAIN, HALTED, STEPPING} (2-bit encoding matches status[1:0])
  - cmd codes
  - cause codes
  - STAGE_ALL = 4'hF
- One sub-module: dbg_cycle_counter, a loadable down-counter with a zero flag. It is instantiated twice: drain (PIPE_DEPTH) and step timeout (STEP_TIMEOUT).

Test Plan:
1. Reset with HALT_ON_RESET=0, then HALT at cycle 10 → DRAIN for 4 cycles (enable_pc_ext=0, enable_ext=F). Then HALTED with enable_ext=0, tx_flag high exactly 1 cycle, status[4:2]=1.
2. From HALTED, STEP with core_retire 3 cycles later → enable_pc_ext high 1 cycle, HALTED, cause 4, status[31:16]=1. Repeat with no retire → HALTED after 64 cycles, cause 5, status[6]=1.
3. From HALTED, RUN_N with step_count=5 and retire every cycle → DRAIN after the 5th retire, cause 3, status[31:16]=5.
4. bp_en=1, bp_addr=32'h0000_0040: run until pc_current=0x40 → DRAIN, cause 2. RESUME → RUNNING does not re-trigger on the same PC in its first cycle.
5. During DRAIN, issue RESUME → ignored, cmd_err=1. Then CLR_ERR → cmd_err=0. RUN_N with step_count=0 from HALTED → stays HALTED, cmd_err=1.
6. Assert RST low mid-STEPPING → immediately RUNNING outputs (enable_ext=F, debug=0), tx_flag never pulses, status=0.

Source files
------------

// File: rtl/debug_run_ctrl_pkg.sv
// Shared types for the debug run-control sequencer.
// State encoding is exported directly on status[1:0].
package debug_ctrl_pkg;

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        DRAIN    = 2'd1,
        HALTED   = 2'd2,
        STEPPING = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_HALT    = 3'd1,
        CMD_RESUME  = 3'd2,
        CMD_STEP    = 3'd3,
        CMD_RUN_N   = 3'd4,
        CMD_CLR_ERR = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        CAUSE_RESET   = 3'd0,
        CAUSE_HOST    = 3'd1,
        CAUSE_BP      = 3'd2,
        CAUSE_COUNT   = 3'd3,
        CAUSE_STEP    = 3'd4,
        CAUSE_TIMEOUT = 3'd5
    } cause_e;

    localparam logic [3:0] STAGE_ALL = 4'hF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Host-side command/status bundle between the debug slave
// registers and the run-control sequencer.
interface debug_run_ctrl_if;

    logic        ctrl_valid;
    logic [2:0]  ctrl_cmd;
    logic [15:0] step_count;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        tx_flag;
    logic [31:0] status;

    modport master (
        output ctrl_valid,
        output ctrl_cmd,
        output step_count,
        output bp_en,
        output bp_addr,
        input  tx_flag,
        input  status
    );

    modport slave (
        input  ctrl_valid,
        input  ctrl_cmd,
        input  step_count,
        input  bp_en,
        input  bp_addr,
        output tx_flag,
        output status
    );

endinterface

// File: rtl/debug_run_ctrl_cycle_counter.sv
// Loadable down-counter with a zero flag; holds at zero.
// Used for pipeline drain and single-step timeout.
module dbg_cycle_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run-control sequencer: halt/resume/step/run-N and PC
// breakpoint, producing the core freeze controls.
module debug_run_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH    = 4,
    parameter int STEP_TIMEOUT  = 64,
    parameter int HALT_ON_RESET = 0
) (
    input  logic               CLK,
    input  logic               RST,
    debug_run_ctrl_if.slave    host,
    input  logic [31:0]        pc_current,
    input  logic               core_retire,
    output logic               debug,
    output logic [3:0]         enable_ext,
    output logic               enable_pc_ext
);

    localparam state_e RST_ST =
        (HALT_ON_RESET != 0) ? HALTED : RUNNING;
    localparam logic [15:0] DRAIN_LD = 16'(PIPE_DEPTH - 1);
    localparam logic [15:0] STEP_LD  = 16'(STEP_TIMEOUT - 1);

    state_e      state_q, state_d;
    cause_e      cause_q, cause_d;
    logic        first_q;
    logic        err_q, to_q;
    logic        runn_q;
    logic [15:0] step_q;
    logic [15:0] cnt_q;

    logic err_set, err_clr, to_set, clr_cnt;
    logic acc_run, acc_res;
    logic drain_zero, step_zero;
    logic bp_hit, cnt_hit;

    logic c_halt, c_resume, c_step, c_runn, c_clr, c_bad;

    assign c_halt   = host.ctrl_valid && host.ctrl_cmd == CMD_HALT;
    assign c_resume = host.ctrl_valid && host.ctrl_cmd == CMD_RESUME;
    assign c_step   = host.ctrl_valid && host.ctrl_cmd == CMD_STEP;
    assign c_runn   = host.ctrl_valid && host.ctrl_cmd == CMD_RUN_N;
    assign c_clr    = host.ctrl_valid && host.ctrl_cmd == CMD_CLR_ERR;
    assign c_bad    = host.ctrl_valid && host.ctrl_cmd > 3'd5;

    // first_q masks the compare so the core can leave a halted-on BP
    assign bp_hit  = host.bp_en && !first_q &&
                     (pc_current == host.bp_addr);
    assign cnt_hit = runn_q && core_retire &&
                     (sat_inc(cnt_q) == step_q);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        err_set = c_bad;
        err_clr = c_clr;
        to_set  = 1'b0;
        clr_cnt = 1'b0;
        acc_run = 1'b0;
        acc_res = 1'b0;
        unique case (state_q)
            RUNNING: begin
                if (c_resume || c_step || c_runn) err_set = 1'b1;
                if (bp_hit) begin
                    state_d = DRAIN;
                    cause_d = CAUSE_BP;
                end else if (cnt_hit) begin
                    state_d = DRAIN;
                    cause_d = CAUSE_COUNT;
                end else if (c_halt) begin
                    state_d = DRAIN;
                    cause_d = CAUSE_HOST;
                end
            end
            DRAIN: begin
                if (c_halt || c_resume || c_step || c_runn)
                    err_set = 1'b1;
                if (drain_zero) state_d = HALTED;
            end
            HALTED: begin
                if (c_resume) begin
                    state_d = RUNNING;
                    acc_res = 1'b1;
                    clr_cnt = 1'b1;
                end else if (c_step) begin
                    state_d = STEPPING;
                    clr_cnt = 1'b1;
                end else if (c_runn) begin
                    if (host.step_count == 16'd0) begin
                        err_set = 1'b1;
                    end else begin
                        state_d = RUNNING;
                        acc_run = 1'b1;
                        clr_cnt = 1'b1;
                    end
                end
            end
            STEPPING: begin
                if (c_halt || c_resume || c_step || c_runn)
                    err_set = 1'b1;
                if (core_retire) begin
                    state_d = HALTED;
                    cause_d = CAUSE_STEP;
                end else if (step_zero) begin
                    state_d = HALTED;
                    cause_d = CAUSE_TIMEOUT;
                    to_set  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RST_ST;
            cause_q <= CAUSE_RESET;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            runn_q  <= 1'b0;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            first_q <= (state_d != state_q);
            err_q   <= err_set | (err_q & ~err_clr);
            to_q    <= to_set | (to_q & ~err_clr);
            if (acc_run) begin
                runn_q <= 1'b1;
                step_q <= host.step_count;
            end else if (acc_res) begin
                runn_q <= 1'b0;
            end
            if (clr_cnt) cnt_q <= '0;
            else if (core_retire) cnt_q <= sat_inc(cnt_q);
        end
    end

    dbg_cycle_counter #(.W(16)) u_drain (
        .CLK      (CLK),
        .RST      (RST),
        .load     (state_d == DRAIN && state_q != DRAIN),
        .load_val (DRAIN_LD),
        .en       (state_q == DRAIN),
        .zero     (drain_zero)
    );

    dbg_cycle_counter #(.W(16)) u_step (
        .CLK      (CLK),
        .RST      (RST),
        .load     (state_d == STEPPING && state_q != STEPPING),
        .load_val (STEP_LD),
        .en       (state_q == STEPPING),
        .zero     (step_zero)
    );

    always_comb begin
        debug         = 1'b1;
        enable_ext    = '0;
        enable_pc_ext = 1'b0;
        unique case (state_q)
            RUNNING: begin
                debug         = 1'b0;
                enable_ext    = STAGE_ALL;
                enable_pc_ext = 1'b1;
            end
            DRAIN:    enable_ext = STAGE_ALL;
            HALTED:   enable_ext = '0;
            STEPPING: begin
                enable_ext    = STAGE_ALL;
                enable_pc_ext = first_q;
            end
        endcase
    end

    assign host.tx_flag = (state_q == HALTED) && first_q;
    assign host.status  = {cnt_q, 9'd0, to_q, err_q,
                           cause_q, state_q};

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed scoreboard bench for debug_run_ctrl.
// Observation vector = {debug, enable_ext, enable_pc_ext, tx_flag, status}.
module tb_debug_run_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] pc_current;
    logic        core_retire;
    logic        debug;
    logic [3:0]  enable_ext;
    logic        enable_pc_ext;

    debug_run_ctrl_if hif();

    debug_run_ctrl #(
        .PIPE_DEPTH    (4),
        .STEP_TIMEOUT  (64),
        .HALT_ON_RESET (0)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .host          (hif),
        .pc_current    (pc_current),
        .core_retire   (core_retire),
        .debug         (debug),
        .enable_ext    (enable_ext),
        .enable_pc_ext (enable_pc_ext)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [38:0] v;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    wire [38:0] obs = {debug, enable_ext, enable_pc_ext,
                       hif.tx_flag, hif.status};

    function automatic logic [31:0] st(int s, int c, int e,
                                       int t, int n);
        return {16'(n), 9'd0, 1'(t), 1'(e), 3'(c), 2'(s)};
    endfunction

    function automatic logic [38:0] mk(logic d, logic [3:0] en,
                                       logic p, logic t,
                                       logic [31:0] s);
        return {d, en, p, t, s};
    endfunction

    task automatic push(input string tag, input logic [38:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_empty observed=%h", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h",
                       e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [15:0] n);
        hif.ctrl_valid = 1'b1;
        hif.ctrl_cmd   = c;
        hif.step_count = n;
    endtask

    // expectation queued with the stimulus, checked after the edge
    task automatic step(input string tag, input logic [38:0] v);
        push(tag, v);
        tick();
        hif.ctrl_valid = 1'b0;
        pop_check();
    endtask

    task automatic chk_now(input string tag, input logic [38:0] v);
        push(tag, v);
        pop_check();
    endtask

    initial begin
        hif.ctrl_valid = 1'b0;
        hif.ctrl_cmd   = 3'd0;
        hif.step_count = 16'd0;
        hif.bp_en      = 1'b0;
        hif.bp_addr    = 32'h0000_0040;
        pc_current     = 32'h0000_0100;
        core_retire    = 1'b0;

        // reset and host halt
        tick();
        tick();
        chk_now("reset", mk(0, 4'hF, 1, 0, 32'd0));
        RST = 1'b1;
        repeat (8) tick();
        chk_now("run_idle", mk(0, 4'hF, 1, 0, st(0, 0, 0, 0, 0)));
        issue(3'd1, 16'd0);
        for (int i = 1; i <= 4; i++)
            step("host_drain", mk(1, 4'hF, 0, 0, st(1, 1, 0, 0, 0)));
        step("host_halt", mk(1, 4'h0, 0, 1, st(2, 1, 0, 0, 0)));
        step("halt_hold", mk(1, 4'h0, 0, 0, st(2, 1, 0, 0, 0)));

        // single step with retire, then timeout
        issue(3'd3, 16'd0);
        step("step_first", mk(1, 4'hF, 1, 0, st(3, 1, 0, 0, 0)));
        step("step_hold", mk(1, 4'hF, 0, 0, st(3, 1, 0, 0, 0)));
        tick();
        core_retire = 1'b1;
        step("step_done", mk(1, 4'h0, 0, 1, st(2, 4, 0, 0, 1)));
        core_retire = 1'b0;
        issue(3'd3, 16'd0);
        step("to_first", mk(1, 4'hF, 1, 0, st(3, 4, 0, 0, 0)));
        for (int i = 2; i <= 64; i++)
            step("to_wait", mk(1, 4'hF, 0, 0, st(3, 4, 0, 0, 0)));
        step("to_halt", mk(1, 4'h0, 0, 1, st(2, 5, 0, 1, 0)));
        issue(3'd5, 16'd0);
        step("clr_to", mk(1, 4'h0, 0, 0, st(2, 5, 0, 0, 0)));

        // run-N
        issue(3'd4, 16'd5);
        step("runn_first", mk(0, 4'hF, 1, 0, st(0, 5, 0, 0, 0)));
        core_retire = 1'b1;
        for (int k = 1; k <= 4; k++)
            step("runn_cnt", mk(0, 4'hF, 1, 0, st(0, 5, 0, 0, k)));
        step("runn_drain", mk(1, 4'hF, 0, 0, st(1, 3, 0, 0, 5)));
        core_retire = 1'b0;
        repeat (3)
            step("runn_drainN", mk(1, 4'hF, 0, 0, st(1, 3, 0, 0, 5)));
        step("runn_halt", mk(1, 4'h0, 0, 1, st(2, 3, 0, 0, 5)));

        // breakpoint and first-cycle mask
        hif.bp_en = 1'b1;
        issue(3'd2, 16'd0);
        step("res_first", mk(0, 4'hF, 1, 0, st(0, 3, 0, 0, 0)));
        step("res_run", mk(0, 4'hF, 1, 0, st(0, 3, 0, 0, 0)));
        pc_current = 32'h0000_0040;
        step("bp_drain", mk(1, 4'hF, 0, 0, st(1, 2, 0, 0, 0)));
        repeat (3)
            step("bp_drainN", mk(1, 4'hF, 0, 0, st(1, 2, 0, 0, 0)));
        step("bp_halt", mk(1, 4'h0, 0, 1, st(2, 2, 0, 0, 0)));
        issue(3'd2, 16'd0);
        step("bp_mask1", mk(0, 4'hF, 1, 0, st(0, 2, 0, 0, 0)));
        step("bp_mask2", mk(0, 4'hF, 1, 0, st(0, 2, 0, 0, 0)));
        pc_current = 32'h0000_0044;
        step("bp_leave", mk(0, 4'hF, 1, 0, st(0, 2, 0, 0, 0)));
        pc_current = 32'h0000_0040;
        issue(3'd1, 16'd0);
        step("bp_over_halt", mk(1, 4'hF, 0, 0, st(1, 2, 0, 0, 0)));

        // command errors
        issue(3'd2, 16'd0);
        step("drain_err", mk(1, 4'hF, 0, 0, st(1, 2, 1, 0, 0)));
        repeat (2)
            step("drain_errN", mk(1, 4'hF, 0, 0, st(1, 2, 1, 0, 0)));
        step("err_halt", mk(1, 4'h0, 0, 1, st(2, 2, 1, 0, 0)));
        issue(3'd5, 16'd0);
        step("clr_err", mk(1, 4'h0, 0, 0, st(2, 2, 0, 0, 0)));
        issue(3'd4, 16'd0);
        step("runn_zero", mk(1, 4'h0, 0, 0, st(2, 2, 1, 0, 0)));
        issue(3'd5, 16'd0);
        step("clr_err2", mk(1, 4'h0, 0, 0, st(2, 2, 0, 0, 0)));
        issue(3'd7, 16'd0);
        step("illegal", mk(1, 4'h0, 0, 0, st(2, 2, 1, 0, 0)));
        issue(3'd1, 16'd0);
        step("halt_halted", mk(1, 4'h0, 0, 0, st(2, 2, 1, 0, 0)));
        issue(3'd5, 16'd0);
        step("clr_err3", mk(1, 4'h0, 0, 0, st(2, 2, 0, 0, 0)));

        // reset mid-step
        hif.bp_en  = 1'b0;
        pc_current = 32'h0000_0100;
        issue(3'd3, 16'd0);
        step("s6_step", mk(1, 4'hF, 1, 0, st(3, 2, 0, 0, 0)));
        step("s6_hold", mk(1, 4'hF, 0, 0, st(3, 2, 0, 0, 0)));
        RST = 1'b0;
        #1;
        chk_now("rst_async", mk(0, 4'hF, 1, 0, 32'd0));
        repeat (3) step("rst_hold", mk(0, 4'hF, 1, 0, 32'd0));
        RST = 1'b1;
        repeat (2) step("rst_exit", mk(0, 4'hF, 1, 0, 32'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
